// File: rtl/cpu_load_pkg.sv
// cpu_load_pkg: shared definitions for the program loader.
//   state_t      - loader FSM states
//   HDR_*        - bit positions of the fields in a segment header word
//   TARGET_*     - values of the header target bit
package cpu_load_pkg;

  typedef enum logic [2:0] {
    HEADER = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    DONE   = 3'd3,
    RUN    = 3'd4
  } state_t;

  localparam int HDR_TARGET_BIT = 31;
  localparam int HDR_GO_BIT     = 30;
  localparam int HDR_ADDR_LSB   = 16;
  localparam int HDR_CNT_W      = 10;

  localparam logic TARGET_INST = 1'b0;
  localparam logic TARGET_DATA = 1'b1;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: turns a valid/ready word stream into instruction/data memory
// write strokes for the CPU load port, holding the CPU in reset while loading.
//
// Stream format per segment: one header word, then 'count' data words
// (count 0 means 1024), then one checksum word when LOADER_CHECKSUM_EN is
// defined. Header: [31] target (0 inst, 1 data), [30] go, [25:16] start
// address, [9:0] count.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_data/in_valid    stream word and its valid
//   in_ready            word accepted this cycle when in_valid is also high
//   reload              one-cycle pulse: halt CPU, wait for a new header
//   inst_data, address  word and target address of the current write
//   write_instruction   instruction-memory write strobe
//   write_data          data-memory write strobe
//   cpu_rst             active-high reset to the CPU
//   busy                high while waiting for or consuming a segment
//   err                 sticky checksum error (cleared only by rst)
//
// Compile option: define LOADER_CHECKSUM_EN to add the trailing checksum word
// per segment and the err flag; without it err is tied low.
module prog_loader
  import cpu_load_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] address,
  output logic              write_instruction,
  output logic              write_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              err
);

  state_t              state;
  logic                target;
  logic                go;
  logic [ADDR_W-1:0]   ptr;
  logic [HDR_CNT_W:0]  remaining;
  logic                accept;

  // reload wins over a handshake in the same cycle: the word is refused.
  assign in_ready = (state == HEADER || state == LOAD || state == CHECK) && !reload;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == HEADER || state == LOAD || state == CHECK);

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= HEADER;
      target            <= TARGET_INST;
      go                <= 1'b0;
      ptr               <= '0;
      remaining         <= '0;
      inst_data         <= '0;
      address           <= '0;
      write_instruction <= 1'b0;
      write_data        <= 1'b0;
      cpu_rst           <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum               <= '0;
      err               <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; address/inst_data hold between writes.
      write_instruction <= 1'b0;
      write_data        <= 1'b0;
      if (reload) begin
        state   <= HEADER;
        cpu_rst <= 1'b1;
      end else begin
        case (state)
          HEADER: if (accept) begin
            target <= in_data[HDR_TARGET_BIT];
            go     <= in_data[HDR_GO_BIT];
            ptr    <= in_data[HDR_ADDR_LSB +: ADDR_W];
            // count field of zero becomes 1 << HDR_CNT_W (1024 words).
            remaining <= {(in_data[HDR_CNT_W-1:0] == '0), in_data[HDR_CNT_W-1:0]};
`ifdef LOADER_CHECKSUM_EN
            sum    <= '0;
`endif
            state  <= LOAD;
          end
          LOAD: if (accept) begin
            inst_data         <= in_data;
            address           <= ptr;
            write_instruction <= (target == TARGET_INST);
            write_data        <= (target == TARGET_DATA);
            ptr               <= ptr + 1'b1;
            remaining         <= remaining - 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum               <= sum + in_data;
            if (remaining == 1) state <= CHECK;
`else
            if (remaining == 1) state <= DONE;
`endif
          end
          CHECK: begin
`ifdef LOADER_CHECKSUM_EN
            if (accept) begin
              if (in_data == sum) begin
                state <= DONE;
              end else begin
                err   <= 1'b1;
                state <= HEADER;
              end
            end
`else
            state <= HEADER;
`endif
          end
          DONE: begin
            if (go) begin
              cpu_rst <= 1'b0;
              state   <= RUN;
            end else begin
              state   <= HEADER;
            end
          end
          RUN: ;
          default: state <= HEADER;
        endcase
      end
    end
  end

endmodule
